// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types and constants for the target-side glitcher logic.
//   mon_state_t  - reset pulse monitor FSM state
//   PULSE_CNT_W  - width of the completed-pulse counter
package glitch_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    LOW       = 2'd2
  } mon_state_t;

  localparam int PULSE_CNT_W = 16;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for a single asynchronous input.
//   clk  - destination clock
//   rst  - asynchronous active-high reset (all stages clear to 0)
//   d    - asynchronous input
//   q    - synchronised output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_reg[0] <= 1'b0;
    else     stage_reg[0] <= d;
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_reg[gi] <= 1'b0;
        else     stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/reset_pulse_monitor.sv
// reset_pulse_monitor: measures active-low reset pulses seen on the target
// reset line, checks each width against [MIN_CYCLES, MAX_CYCLES] and counts
// completed pulses.
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   rst_n_in    - monitored target reset line (active-low, asynchronous)
//   clear       - synchronous clear of width / width_ok / pulse_count
//   line_low    - synchronised line level inverted (1 = target in reset)
//   done        - one-cycle strobe when a pulse completes
//   width       - width of last completed pulse, in clk cycles
//   width_ok    - last width was inside the legal window
//   too_long    - current pulse has already exceeded MAX_CYCLES
//   pulse_count - completed pulses since reset/clear, saturating
module reset_pulse_monitor
  import glitch_pkg::*;
#(
  parameter int MIN_CYCLES  = 100,
  parameter int MAX_CYCLES  = 200,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_n_in,
  input  logic                   clear,
  output logic                   line_low,
  output logic                   done,
  output logic [CNT_W-1:0]       width,
  output logic                   width_ok,
  output logic                   too_long,
  output logic [PULSE_CNT_W-1:0] pulse_count
);

  localparam logic [CNT_W-1:0]       CNT_SAT = '1;
  localparam logic [CNT_W-1:0]       MIN_C   = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0]       MAX_C   = CNT_W'(MAX_CYCLES);
  localparam logic [PULSE_CNT_W-1:0] PCNT_SAT = '1;

  logic s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rst_n_in),
    .q   (s)
  );

  assign line_low = ~s;

  mon_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   done_reg, done_next;
  logic [CNT_W-1:0]       width_reg, width_next;
  logic                   width_ok_reg, width_ok_next;
  logic                   too_long_reg, too_long_next;
  logic [PULSE_CNT_W-1:0] pcount_reg, pcount_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= WAIT_HIGH;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      width_reg    <= '0;
      width_ok_reg <= 1'b0;
      too_long_reg <= 1'b0;
      pcount_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      done_reg     <= done_next;
      width_reg    <= width_next;
      width_ok_reg <= width_ok_next;
      too_long_reg <= too_long_next;
      pcount_reg   <= pcount_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    done_next     = 1'b0;
    width_next    = width_reg;
    width_ok_next = width_ok_reg;
    too_long_next = too_long_reg;
    pcount_next   = pcount_reg;

    // Clear only touches the reported results; a completion in the same
    // cycle overrides it below.
    if (clear) begin
      width_next    = '0;
      width_ok_next = 1'b0;
      pcount_next   = '0;
    end

    case (state_reg)
      // A line already low at power-up/reset is a partial pulse: skip it.
      WAIT_HIGH: begin
        too_long_next = 1'b0;
        if (s) state_next = IDLE;
      end
      IDLE: begin
        if (!s) begin
          state_next    = LOW;
          cnt_next      = CNT_W'(1);
          too_long_next = (CNT_W'(1) > MAX_C);
        end
      end
      LOW: begin
        if (!s) begin
          if (cnt_reg != CNT_SAT) cnt_next = cnt_reg + CNT_W'(1);
          too_long_next = (cnt_next > MAX_C);
        end else begin
          state_next    = IDLE;
          too_long_next = 1'b0;
          done_next     = 1'b1;
          width_next    = cnt_reg;
          // A saturated count is not a real measurement, never legal.
          width_ok_next = (cnt_reg >= MIN_C) && (cnt_reg <= MAX_C) &&
                          (cnt_reg != CNT_SAT);
          if (clear)                    pcount_next = PULSE_CNT_W'(1);
          else if (pcount_reg != PCNT_SAT) pcount_next = pcount_reg + PULSE_CNT_W'(1);
        end
      end
      default: state_next = WAIT_HIGH;
    endcase
  end

  assign done        = done_reg;
  assign width       = width_reg;
  assign width_ok    = width_ok_reg;
  assign too_long    = too_long_reg;
  assign pulse_count = pcount_reg;

endmodule
